// File: rtl/cmp2_pkg.sv
// cmp2_pkg: shared definitions for the two's-complement decoder.
//   - state_e     : decoder FSM states
//   - DefW / DefD : default word width and BCD digit count
//   - req_digits  : smallest digit count D with 10^D > 2^(w-1)
package cmp2_pkg;

    localparam int unsigned DefW = 9;
    localparam int unsigned DefD = 3;

    typedef enum logic [1:0] {
        StIdle,
        StNeg,
        StBcd,
        StDone
    } state_e;

    // Largest magnitude of a w-bit two's-complement word is 2^(w-1), so the
    // digit count must cover that value exactly.
    function automatic int unsigned req_digits(input int unsigned w);
        longint unsigned lim;
        longint unsigned p;
        int unsigned     d;
        lim = 64'd1 << (w - 1);
        p   = 64'd1;
        d   = 0;
        while (p <= lim) begin
            p = p * 64'd10;
            d = d + 1;
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_adj4.sv
// bcd_adj4: combinational double-dabble digit correction.
//   din  : one BCD digit before the shift
//   dout : din + 3 when din >= 5, otherwise din unchanged
module bcd_adj4 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    always_comb begin
        dout = din;
        if (din >= 4'd5) begin
            dout = din + 4'd3;
        end
    end

endmodule

// File: rtl/cmp2_dec.sv
// cmp2_dec: two's-complement word decoder.
// Accepts a signed word, recovers sign and magnitude with a bit-serial
// complement (LSB first: copy up to the first 1, invert the rest), then
// converts the magnitude to packed BCD with serial double-dabble.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in, in_valid         : input word and its valid
//   in_ready             : high only while idle
//   sign, mag, bcd       : registered result, held until the next result
//   out_valid, out_ready : result handshake
// Latency from the accept edge: W+1 cycles for positive words, 2W+1 for
// negative ones.
module cmp2_dec
    import cmp2_pkg::*;
#(
    parameter int unsigned W = DefW,
    parameter int unsigned D = DefD
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [W-1:0]   in,
    input  logic           in_valid,
    output logic           in_ready,
    output logic           sign,
    output logic [W-1:0]   mag,
    output logic [4*D-1:0] bcd,
    output logic           out_valid,
    input  logic           out_ready
);

    localparam int unsigned CntW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(W - 1);

    generate
        if (W < 2) begin : g_bad_w
            $fatal(1, "cmp2_dec: W=%0d must be at least 2", W);
        end
        if (D < req_digits(W)) begin : g_bad_d
            $fatal(1, "cmp2_dec: D=%0d too small for W=%0d (need %0d)", D, W,
                   req_digits(W));
        end
    endgenerate

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [W-1:0]    sh_q;       // input word, consumed LSB first in StNeg
    logic            seen_q;     // a 1 has already passed in the complement
    logic [W-1:0]    bin_q;      // binary half of the double-dabble register
    logic [W-1:0]    mag_w_q;    // working magnitude, survives the BCD shifts
    logic [4*D-1:0]  dd_bcd_q;   // BCD half of the double-dabble register
    logic            sign_w_q;
    logic            in_ready_q;
    logic            sign_q;
    logic [W-1:0]    mag_q;
    logic [4*D-1:0]  bcd_q;
    logic            out_valid_q;

    logic               neg_bit;
    logic [4*D-1:0]     dig_adj;
    logic [4*D+W-1:0]   dd_shift;

    // Complement bit for the current LSB.
    assign neg_bit = seen_q ? ~sh_q[0] : sh_q[0];

    for (genvar i = 0; i < D; i++) begin : g_adj
        bcd_adj4 u_adj (
            .din  (dd_bcd_q[4*i +: 4]),
            .dout (dig_adj[4*i +: 4])
        );
    end

    // One double-dabble step: corrected digits and binary shifted left as one.
    always_comb begin
        dd_shift = {dig_adj, bin_q} << 1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            sh_q        <= '0;
            seen_q      <= 1'b0;
            bin_q       <= '0;
            mag_w_q     <= '0;
            dd_bcd_q    <= '0;
            sign_w_q    <= 1'b0;
            in_ready_q  <= 1'b0;
            sign_q      <= 1'b0;
            mag_q       <= '0;
            bcd_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid && in_ready_q) begin
                        sh_q       <= in;
                        seen_q     <= 1'b0;
                        cnt_q      <= '0;
                        sign_w_q   <= in[W-1];
                        dd_bcd_q   <= '0;
                        in_ready_q <= 1'b0;
                        if (in[W-1]) begin
                            state_q <= StNeg;
                        end else begin
                            bin_q   <= in;
                            mag_w_q <= in;
                            state_q <= StBcd;
                        end
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end

                StNeg: begin
                    sh_q    <= sh_q >> 1;
                    seen_q  <= seen_q | sh_q[0];
                    // Result bits enter from the top so the LSB lands at bit 0.
                    bin_q   <= {neg_bit, bin_q[W-1:1]};
                    mag_w_q <= {neg_bit, mag_w_q[W-1:1]};
                    if (cnt_q == CntLast) begin
                        cnt_q   <= '0;
                        state_q <= StBcd;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end

                StBcd: begin
                    dd_bcd_q <= dd_shift[4*D+W-1:W];
                    bin_q    <= dd_shift[W-1:0];
                    if (cnt_q == CntLast) begin
                        cnt_q   <= '0;
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end

                StDone: begin
                    // First cycle publishes the result; later cycles wait for
                    // the consumer.
                    if (!out_valid_q) begin
                        sign_q      <= sign_w_q;
                        mag_q       <= mag_w_q;
                        bcd_q       <= dd_bcd_q;
                        out_valid_q <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign sign      = sign_q;
    assign mag       = mag_q;
    assign bcd       = bcd_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_cmp2_dec.sv
// tb_cmp2_dec: scoreboard bench for cmp2_dec (W=9, D=3).
// The driver pushes the expected result when a word is accepted; a monitor
// pops it when out_valid rises and checks result and latency every cycle
// the result is presented.
module tb_cmp2_dec;

    localparam int W = 9;
    localparam int D = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [W-1:0]   in_w = '0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic           sign;
    logic [W-1:0]   mag;
    logic [4*D-1:0] bcd;
    logic           out_valid;
    logic           out_ready = 1'b1;

    cmp2_dec #(
        .W (W),
        .D (D)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in_w),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sign      (sign),
        .mag       (mag),
        .bcd       (bcd),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic           s;
        logic [W-1:0]   m;
        logic [4*D-1:0] b;
        int             lat;
        int             acc;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    logic have_cur = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Issue one word; expected values are given by the caller.
    task automatic send(input logic [W-1:0] w, input logic s, input logic [W-1:0] m,
                        input logic [4*D-1:0] b);
        exp_t e;
        int   n;
        @(negedge clk);
        in_w     = w;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("in_ready timeout", {31'd0, in_ready}, 32'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            e.s   = s;
            e.m   = m;
            e.b   = b;
            e.lat = s ? 2 * W + 1 : W + 1;
            e.acc = cyc;
            sb.push_back(e);
            in_valid = 1'b0;
        end
    endtask

    task automatic send_model(input logic [W-1:0] w);
        int m;
        logic [4*D-1:0] b;
        m = w[W-1] ? (1 << W) - int'(w) : int'(w);
        b = {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
        send(w, w[W-1], W'(m), b);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() > 0 || out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain pending", 32'(sb.size()), 32'd0);
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, " out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, " sign"}, {31'd0, sign}, 32'd0);
        chk({tag, " mag"}, 32'(mag), 32'd0);
        chk({tag, " bcd"}, 32'(bcd), 32'd0);
    endtask

    // Monitor
    initial begin
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (out_valid && !prev) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected out_valid: got 1 with empty scoreboard (t=%0t)",
                             $time);
                    have_cur = 1'b0;
                end else begin
                    cur      = sb.pop_front();
                    have_cur = 1'b1;
                    chk("latency", 32'(cyc - cur.acc), 32'(cur.lat));
                end
            end
            if (out_valid && have_cur) begin
                chk("sign", {31'd0, sign}, {31'd0, cur.s});
                chk("mag", 32'(mag), 32'(cur.m));
                chk("bcd", 32'(bcd), 32'(cur.b));
                chk("in_ready in done", {31'd0, in_ready}, 32'd0);
            end
            prev = out_valid;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    // Driver
    initial begin
        int n;

        // Power-on reset
        #12;
        chk_cleared("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready after release", {31'd0, in_ready}, 32'd1);
        chk_cleared("post-release");

        // Directed vectors
        send(9'h0FF, 1'b0, 9'd255, 12'h255);
        send(9'h100, 1'b1, 9'd256, 12'h256);
        send(9'h1FF, 1'b1, 9'd1,   12'h001);
        send(9'h000, 1'b0, 9'd0,   12'h000);
        send(9'h14C, 1'b1, 9'd180, 12'h180);
        drain();

        // Backpressure with a competing word on the input
        out_ready = 1'b0;
        send(9'h07B, 1'b0, 9'd123, 12'h123);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("backpressure out_valid", {31'd0, out_valid}, 32'd1);
        @(negedge clk);
        in_w     = 9'h1D3;
        in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("in_ready held low", {31'd0, in_ready}, 32'd0);
            chk("out_valid held", {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        send(9'h1D3, 1'b1, 9'd45, 12'h045);
        drain();

        // Reset during NEG, cycle 4 of 9
        send(9'h1AB, 1'b1, 9'd85, 12'h085);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_cleared("async reset");
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready after mid reset", {31'd0, in_ready}, 32'd1);
        chk("out_valid after mid reset", {31'd0, out_valid}, 32'd0);
        send(9'h1F6, 1'b1, 9'd10, 12'h010);
        drain();

        // Exhaustive sweep against the reference model
        for (int i = 0; i < (1 << W); i++) begin
            send_model(W'(i));
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cmp2_dec.md
Name: cmp2_dec

Overview:
- Decoder counterpart of the team's two's-complement encoder.
- Accepts a signed two's-complement word over a valid/ready handshake.
- Recovers sign and magnitude with a bit-serial complement (LSB-first "copy up to first 1, invert the rest").
- Converts the magnitude to packed BCD by serial double-dabble for the 7-segment display path.

Parameters:
- W, 9, input word width in bits (two's complement); range -2^(W-1)..2^(W-1)-1.
- D, 3, BCD digit count; must satisfy 10^D > 2^(W-1) (elaboration-time check, fatal if violated).

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- IN  input  W  two's-complement word.
- IN_VALID  input  1  IN is valid.
- IN_READY  output  1  block can accept a word.
- SIGN  output  1  1 = input was negative.
- MAG  output  W  unsigned magnitude |IN|.
- BCD  output  4*D  packed BCD of MAG, most significant digit in the top nibble.
- OUT_VALID  output  1  SIGN/MAG/BCD are valid.
- OUT_READY  input  1  consumer accepts the result.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset (async assert, sync release): state=IDLE; IN_READY=1 from the first edge after release. SIGN, MAG, BCD and OUT_VALID are 0. All internal shift registers and counters are 0.
- FSM states: IDLE, NEG, BCD, DONE.
- IDLE:
  - IN_READY=1.
  - Accept on IN_VALID&IN_READY: capture IN into a shift register and set SIGN=IN[W-1].
  - If SIGN=1, go to NEG; otherwise load MAG=IN and go to BCD.
- NEG: exactly W cycles, LSB first.
  - Output bit = seen ? ~b : b; then seen |= b.
  - Result bits shift into MAG.
  - The counter reaches W-1, then go to BCD.
- BCD: exactly W cycles of double-dabble on a {BCD, MAG copy} register.
  - Before each shift, add 3 to every digit >= 5.
  - After W shifts, go to DONE.
- DONE:
  - OUT_VALID=1, IN_READY=0.
  - SIGN, MAG and BCD are held stable until OUT_VALID&OUT_READY.
  - On handshake, OUT_VALID drops and the FSM returns to IDLE the next cycle.
- Latency (accept edge = k): OUT_VALID rises at edge k+W+1 (positive) or k+2W+1 (negative). With W=9 that is 10 and 19 cycles.
- IN_READY is 1 only in IDLE. IN_VALID outside IDLE is ignored; no buffering; one word in flight.
- Width rules:
  - MAG is W bits wide, so -2^(W-1) (e.g. 9'h100 = -256) yields MAG=256 with no overflow.
  - Zero gives SIGN=0, MAG=0, BCD=0.
  - -0 does not exist.
- SIGN, MAG and BCD outputs are registered.
- Between results (not DONE), outputs retain the previous result; only OUT_VALID qualifies them.
- Reset mid-operation (any state): the in-flight word is discarded, all outputs go to 0 immediately (async), and the FSM restarts in IDLE.
- OUT_READY high while OUT_VALID=0 has no effect.
- OUT_READY held high during DONE: completes in the first DONE cycle.

Decomposition:
- Shared package cmp2_pkg holds:
  - the FSM state enum (IDLE, NEG, BCD, DONE);
  - the default W/D constants;
  - a function returning the required D for a given W, used by the elaboration check.
- One natural sub-module: bcd_adj4, a combinational per-nibble add-3-if->=5 adjust. It is instantiated D times in the double-dabble stage.

Test Plan:
- Reset: assert RST_N=0 mid-run, release → OUT_VALID=0, SIGN/MAG/BCD=0, IN_READY=1 on the first edge after release.
- IN=9'h0FF (+255) → SIGN=0, MAG=255, BCD=12'h255, OUT_VALID exactly 10 cycles after accept.
- IN=9'h100 (-256) → SIGN=1, MAG=256, BCD=12'h256, OUT_VALID exactly 19 cycles after accept.
- IN=9'h1FF (-1), then IN=9'h000 → (1, 1, 12'h001), then (0, 0, 12'h000); also IN=9'h14C (-180) → (1, 180, 12'h180).
- Backpressure: OUT_READY=0 for 5 cycles in DONE while IN_VALID=1 with a new word → outputs stable, IN_READY=0, new word not captured; raise OUT_READY → next word accepted in IDLE.
- Reset pulse during NEG (cycle 4 of 9) → outputs clear asynchronously; a subsequent IN=9'h1F6 (-10) decodes to (1, 10, 12'h010).
- Exhaustive sweep of all 512 inputs against a reference model: SIGN, MAG and BCD match, and latency matches the sign-dependent rule.
